// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the PC fetch sequencer: FSM states, next-PC
// select codes, trap causes and the reset-time instruction word.
package pc_seq_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned WDOG_W = 8;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SEL_JAL   = 2'b01;
  localparam logic [1:0] PC_SEL_JALR  = 2'b10;
  localparam logic [1:0] PC_SEL_RSVD  = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection with word-alignment check of the result.
module pc_next_calc
  import pc_seq_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      pc_sel_i,
  input  logic [XLEN-1:0] jal_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misaligned_o
);

  // Reserved select falls back to sequential PC+4
  always_comb begin
    next_pc_o = pc_i + XLEN'(4);
    case (pc_sel_i)
      PC_SEL_JAL:  next_pc_o = jal_target_i;
      PC_SEL_JALR: next_pc_o = {jalr_target_i[XLEN-1:1], 1'b0};
      default:     next_pc_o = pc_i + XLEN'(4);
    endcase
    misaligned_o = !is_word_aligned(next_pc_o);
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch/execute sequencer: owns the PC, issues instruction fetches with a
// watchdog, latches the instruction for decode and traps on faults.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int unsigned     FETCH_TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      pc_sel_i,
  input  logic [XLEN-1:0] jal_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  input  logic            exec_done_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_valid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic            trap_o,
  output logic [1:0]      trap_cause_o
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(FETCH_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [1:0]        cause_q, cause_d;
  logic              imem_req_q, imem_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic              trap_q, trap_d;

  logic [XLEN-1:0]   next_pc;
  logic              next_misaligned;

  pc_next_calc u_next (
    .pc_i          (pc_q),
    .pc_sel_i      (pc_sel_i),
    .jal_target_i  (jal_target_i),
    .jalr_target_i (jalr_target_i),
    .next_pc_o     (next_pc),
    .misaligned_o  (next_misaligned)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_RESET;
      pc_q          <= RESET_VECTOR;
      instr_q       <= NOP_INSTR;
      wdog_q        <= '0;
      cause_q       <= CAUSE_NONE;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      wdog_q        <= wdog_d;
      cause_q       <= cause_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      trap_q        <= trap_d;
    end
  end

  // Next-state logic; registered strobes are derived from the next state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wdog_d  = wdog_q;
    cause_d = cause_q;
    case (state_q)
      S_RESET: begin
        wdog_d  = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // A response on the expiry cycle beats the watchdog
        if (imem_valid_i) begin
          instr_d = imem_rdata_i;
          wdog_d  = '0;
          state_d = S_EXEC;
        end else if (wdog_q == WDOG_LAST) begin
          wdog_d  = '0;
          cause_d = CAUSE_TIMEOUT;
          state_d = S_TRAP;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_EXEC: begin
        if (exec_done_i) begin
          if (next_misaligned) begin
            cause_d = CAUSE_MISALIGN;
            state_d = S_TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
    imem_req_d    = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_EXEC);
    trap_d        = (state_d == S_TRAP);
  end

  assign imem_req_o    = imem_req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign pc_o          = pc_q;
  assign trap_o        = trap_q;
  assign trap_cause_o  = cause_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed fetch/execute sequences
// push expected decode and trap events; a negedge monitor pops and compares.
module tb_pc_fetch_sequencer;

  localparam int unsigned TMO = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] jal_t = '0;
  logic [31:0] jalr_t = '0;
  logic        exec_done = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        trap;
  logic [1:0]  trap_cause;

  pc_fetch_sequencer #(
    .RESET_VECTOR  (32'h0000_0000),
    .FETCH_TIMEOUT (TMO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_sel_i      (pc_sel),
    .jal_target_i  (jal_t),
    .jalr_target_i (jalr_t),
    .exec_done_i   (exec_done),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_valid_i  (imem_valid),
    .imem_rdata_i  (imem_rdata),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .pc_o          (pc),
    .trap_o        (trap),
    .trap_cause_o  (trap_cause)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exec_exp_t;
  typedef struct { logic [1:0] cause; logic [31:0] pc; int cyc; } trap_exp_t;

  exec_exp_t exec_q[$];
  trap_exp_t trap_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a rising INSTR_VALID or TRAP pops the matching expectation
  logic iv_prev = 1'b0;
  logic tr_prev = 1'b0;
  always @(negedge clk) begin
    if (instr_valid && !iv_prev) begin
      if (exec_q.size() == 0) begin
        chk("unexpected_exec_pc", pc, 32'hxxxx_xxxx);
      end else begin
        exec_exp_t e;
        e = exec_q.pop_front();
        chk("exec_pc", pc, e.pc);
        chk("exec_instr", instr, e.instr);
        chk("exec_imem_req", 32'(imem_req), 32'd0);
      end
    end
    if (trap && !tr_prev) begin
      if (trap_q.size() == 0) begin
        chk("unexpected_trap_cause", 32'(trap_cause), 32'hxxxx_xxxx);
      end else begin
        trap_exp_t t;
        t = trap_q.pop_front();
        chk("trap_cause", 32'(trap_cause), 32'(t.cause));
        chk("trap_pc", pc, t.pc);
        chk("trap_req_iv", 32'({imem_req, instr_valid}), 32'd0);
        if (t.cyc >= 0) chk("trap_cycle", 32'(cyc), 32'(t.cyc));
      end
    end
    iv_prev <= instr_valid;
    tr_prev <= trap;
  end

  // which: 0 = IMEM_REQ, 1 = INSTR_VALID, 2 = TRAP
  task automatic wait_for(input int which);
    int n = 0;
    logic s;
    forever begin
      s = (which == 0) ? imem_req : (which == 1) ? instr_valid : trap;
      if (s || n >= 200) break;
      @(negedge clk);
      n++;
    end
    if (!s) chk($sformatf("wait_timeout_%0d", which), 32'd0, 32'd1);
  endtask

  task automatic push_exec(input logic [31:0] p, input logic [31:0] w);
    exec_exp_t e;
    e.pc = p;
    e.instr = w;
    exec_q.push_back(e);
  endtask

  task automatic push_trap(input logic [1:0] c, input logic [31:0] p, input int cy);
    trap_exp_t t;
    t.cause = c;
    t.pc = p;
    t.cyc = cy;
    trap_q.push_back(t);
  endtask

  task automatic fetch(input logic [31:0] w, input int wait_n);
    wait_for(0);
    imem_rdata = 32'hDEAD_BEEF;
    repeat (wait_n) @(negedge clk);
    imem_valid = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic exec(input logic [1:0] sel, input logic [31:0] jt, input logic [31:0] jrt);
    wait_for(1);
    pc_sel = sel;
    jal_t = jt;
    jalr_t = jrt;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0000_0013);
    chk({tag, "_iv"}, 32'(instr_valid), 32'd0);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_trap"}, 32'(trap), 32'd0);
    chk({tag, "_cause"}, 32'(trap_cause), 32'd0);
    rst = 1'b0;
    exec_done = 1'b0;
    imem_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c0;
    @(negedge clk);
    do_reset("rst0");

    // Basic fetch with one wait cycle, then sequential PC+4
    push_exec(32'h0, 32'h0050_0093);
    fetch(32'h0050_0093, 1);
    exec(2'b00, 32'h0, 32'h0);
    wait_for(0);
    chk("seq_pc", pc, 32'h4);
    chk("seq_addr", imem_addr, 32'h4);

    // Zero-wait fetch, JAL to 0x100
    push_exec(32'h4, 32'h0FC0_006F);
    fetch(32'h0FC0_006F, 0);
    exec(2'b01, 32'h100, 32'h0);

    // JALR with bit 0 set is cleared -> 0x204
    push_exec(32'h100, 32'h0000_8067);
    fetch(32'h0000_8067, 2);
    exec(2'b10, 32'h0, 32'h205);
    wait_for(0);
    chk("jalr_pc", pc, 32'h204);
    chk("jalr_no_trap", 32'(trap), 32'd0);

    push_exec(32'h204, 32'hEFDF_F06F);
    fetch(32'hEFDF_F06F, 0);
    exec(2'b01, 32'h100, 32'h0);

    // JALR to 0x206 is misaligned: trap, PC held
    push_exec(32'h100, 32'h0000_8067);
    push_trap(2'b01, 32'h100, -1);
    fetch(32'h0000_8067, 1);
    exec(2'b10, 32'h0, 32'h206);
    wait_for(2);
    pc_sel = 2'b00;
    exec_done = 1'b1;
    repeat (2) @(negedge clk);
    exec_done = 1'b0;
    chk("trap_sticky", 32'(trap), 32'd1);
    chk("trap_sticky_pc", pc, 32'h100);
    chk("trap_sticky_cause", 32'(trap_cause), 32'd1);

    do_reset("rst_trap");

    // PC+4 wraps at the top of the address space, reserved select too
    push_exec(32'h0, 32'h0000_0013);
    fetch(32'h0000_0013, 0);
    exec(2'b01, 32'hFFFF_FFFC, 32'h0);
    push_exec(32'hFFFF_FFFC, 32'h1111_1111);
    fetch(32'h1111_1111, 1);
    exec(2'b00, 32'h0, 32'h0);
    wait_for(0);
    chk("wrap00_pc", pc, 32'h0);
    push_exec(32'h0, 32'h2222_2222);
    fetch(32'h2222_2222, 0);
    exec(2'b01, 32'hFFFF_FFFC, 32'h0);
    push_exec(32'hFFFF_FFFC, 32'h3333_3333);
    fetch(32'h3333_3333, 0);
    exec(2'b11, 32'h40, 32'h81);
    wait_for(0);
    chk("wrap11_pc", pc, 32'h0);

    // Reset in S_EXEC beats a simultaneous EXEC_DONE
    push_exec(32'h0, 32'h4444_4444);
    fetch(32'h4444_4444, 0);
    wait_for(1);
    pc_sel = 2'b01;
    jal_t = 32'h40;
    exec_done = 1'b1;
    do_reset("rst_exec");
    push_exec(32'h0, 32'h5555_5555);
    fetch(32'h5555_5555, 0);
    exec(2'b00, 32'h0, 32'h0);
    wait_for(0);
    chk("restart_pc", pc, 32'h4);

    // Watchdog expiry: trap exactly TMO cycles after entering fetch
    do_reset("rst_tmo");
    wait_for(0);
    c0 = cyc;
    push_trap(2'b10, 32'h0, c0 + int'(TMO));
    wait_for(2);

    // Response on the expiry cycle wins; EXEC_DONE during fetch ignored
    do_reset("rst_exp");
    wait_for(0);
    push_exec(32'h0, 32'h6666_6666);
    pc_sel = 2'b01;
    jal_t = 32'h80;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    repeat (TMO - 2) @(negedge clk);
    imem_valid = 1'b1;
    imem_rdata = 32'h6666_6666;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("expiry_no_trap", 32'(trap), 32'd0);
    chk("expiry_iv", 32'(instr_valid), 32'd1);
    exec(2'b00, 32'h0, 32'h0);
    wait_for(0);
    chk("expiry_next_pc", pc, 32'h4);

    repeat (3) @(negedge clk);
    chk("exec_q_drained", 32'(exec_q.size()), 32'd0);
    chk("trap_q_drained", 32'(trap_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FETCH_TIMEOUT, 16, max cycles a fetch waits for IMEM_VALID; legal range 2..255.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 PC_SEL  in  2  next-PC select from branch logic: 00 PC+4, 01 JAL target, 10 JALR target, 11 reserved.
REQ-006 JAL_TARGET  in  32  PC-relative target for JAL and taken SB branches.
REQ-007 JALR_TARGET  in  32  rs1+imm target for JALR, with bit 0 not yet cleared.
REQ-008 EXEC_DONE  in  1  datapath has finished the current instruction; PC_SEL and targets are valid this cycle.
REQ-009 IMEM_REQ  out  1  instruction fetch request.
REQ-010 IMEM_ADDR  out  32  fetch address; always equals PC.
REQ-011 IMEM_VALID  in  1  IMEM_RDATA is valid; sampled only while IMEM_REQ=1.
REQ-012 IMEM_RDATA  in  32  fetched instruction word.
REQ-013 INSTR  out  32  latched instruction presented to decode.
REQ-014 INSTR_VALID  out  1  INSTR is valid for execution.
REQ-015 PC  out  32  address of the current instruction.
REQ-016 TRAP  out  1  sticky fault flag.
REQ-017 TRAP_CAUSE  out  2  fault cause: 00 none, 01 misaligned target, 10 fetch timeout.

Function
REQ-018 FSM states: S_RESET, S_FETCH, S_EXEC, S_TRAP.
REQ-019 S_RESET goes to S_FETCH on the first cycle with RST=0.
REQ-020 S_FETCH: IMEM_REQ=1, INSTR_VALID=0, and the watchdog counter increments each cycle.
REQ-021 S_FETCH with IMEM_VALID=1: INSTR<=IMEM_RDATA, counter<=0, next state S_EXEC; a zero-wait response in the first S_FETCH cycle is legal.
REQ-022 S_FETCH when the counter reaches FETCH_TIMEOUT-1 without IMEM_VALID: next state S_TRAP, TRAP_CAUSE<=10.
REQ-023 If IMEM_VALID arrives in the same cycle the watchdog expires, IMEM_VALID wins and no trap is raised.
REQ-024 S_EXEC: INSTR_VALID=1, IMEM_REQ=0; hold until EXEC_DONE=1.
REQ-025 On EXEC_DONE, next PC is selected by PC_SEL:
- 00 or 11: PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- 01: JAL_TARGET.
- 10: {JALR_TARGET[31:1],1'b0}.
REQ-026 If the selected next PC has bits[1:0]!=00: PC is unchanged, TRAP_CAUSE<=01, next state S_TRAP.
REQ-027 Otherwise: PC<=next PC, next state S_FETCH; minimum 2 cycles per instruction.
REQ-028 EXEC_DONE outside S_EXEC is ignored.
REQ-029 S_TRAP: TRAP=1, IMEM_REQ=0, INSTR_VALID=0; the state is left only by RST.
REQ-030 IMEM_RDATA is ignored whenever IMEM_VALID=0 or state!=S_FETCH.

Reset
REQ-031 RST=1 has priority over every event, including mid-fetch and mid-execute.
REQ-032 Values on the edge with RST=1:
- state S_RESET, PC=RESET_VECTOR, watchdog counter=0;
- INSTR=32'h0000_0013 (NOP), INSTR_VALID=0, IMEM_REQ=0;
- TRAP=0, TRAP_CAUSE=00.
REQ-033 A memory response that arrives after reset is released and belongs to a pre-reset request is not tracked; the memory shall drop outstanding requests on RST.

Structure
REQ-034 Shared package pc_seq_pkg holds:
- state enum;
- PC_SEL encodings;
- trap cause encodings;
- NOP constant.
REQ-035 One sub-module, pc_next_calc: combinational next-PC mux plus alignment check, exposing outputs NEXT_PC and MISALIGNED.

Verification
REQ-036 Reset, then IMEM_VALID one cycle after request with 0x00500093, then EXEC_DONE with PC_SEL=00 -> INSTR=0x00500093, INSTR_VALID high 1+ cycles, PC=0x4, IMEM_ADDR=0x4.
REQ-037 PC=0x100, PC_SEL=10, JALR_TARGET=0x205 -> PC=0x204, no trap; JALR_TARGET=0x206 -> TRAP=1, TRAP_CAUSE=01, PC stays 0x100.
REQ-038 IMEM_VALID never asserted -> TRAP_CAUSE=10 exactly FETCH_TIMEOUT cycles after entering S_FETCH; IMEM_VALID on the expiry cycle -> no trap.
REQ-039 PC=0xFFFF_FFFC, PC_SEL=00 -> PC=0x0000_0000; PC_SEL=11 -> identical result to 00.
REQ-040 RST pulsed during S_EXEC and again in S_TRAP -> next cycle all outputs equal REQ-032 values, and fetch restarts at RESET_VECTOR.
